// File: rtl/config_word_loader.sv
// Serial-to-parallel config loader: shifts cfg_bit MSB-first into words and writes word i
// through a one-hot wr_sel strobe. Optional per-word even parity under CFG_PARITY_EN.
module config_word_loader #(
  parameter int unsigned N_WORDS = 4,
  parameter int unsigned WORD_W  = 8,
  parameter int unsigned ADDR_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               cfg_bit,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  output logic [WORD_W-1:0]  wr_data,
  output logic [N_WORDS-1:0] wr_sel,
  output logic               wr_en,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef CFG_PARITY_EN
  localparam int unsigned ShiftW = WORD_W + 1;
`else
  localparam int unsigned ShiftW = WORD_W;
`endif
  localparam int unsigned CntW = $clog2(ShiftW);

  typedef enum logic [1:0] {StIdle, StShift, StWrite, StDone} state_e;

  state_e              state_q, state_d;
  logic [ShiftW-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0]   word_idx_q, word_idx_d;
  logic                word_ok;

`ifdef CFG_PARITY_EN
  logic err_q, err_d;
  // Word plus its trailing parity bit must XOR to zero.
  assign word_ok = ~(^shift_q);
  assign err     = err_q;
`else
  assign word_ok = 1'b1;
  assign err     = 1'b0;
`endif

  assign wr_data = shift_q[ShiftW-1 -: WORD_W];
  assign busy    = (state_q == StShift) || (state_q == StWrite);
  assign done    = (state_q == StDone);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    word_idx_d = word_idx_q;
`ifdef CFG_PARITY_EN
    err_d      = err_q;
`endif
    cfg_ready  = 1'b0;
    wr_en      = 1'b0;
    wr_sel     = '0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d    = StShift;
          bit_cnt_d  = '0;
          word_idx_d = '0;
`ifdef CFG_PARITY_EN
          err_d      = 1'b0;
`endif
        end
      end
      StShift: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          shift_d = {shift_q[ShiftW-2:0], cfg_bit};
          if (bit_cnt_q == CntW'(ShiftW - 1)) begin
            bit_cnt_d = '0;
            state_d   = StWrite;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StWrite: begin
        wr_en = word_ok;
        if (word_ok) begin
          wr_sel = N_WORDS'(1) << word_idx_q;
        end
`ifdef CFG_PARITY_EN
        if (!word_ok) begin
          err_d = 1'b1;
        end
`endif
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (word_idx_q == ADDR_W'(N_WORDS - 1)) ? StDone : StShift;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      word_idx_q <= '0;
`ifdef CFG_PARITY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      word_idx_q <= word_idx_d;
`ifdef CFG_PARITY_EN
      err_q      <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_config_word_loader.sv
// Bench for config_word_loader: bit-queue driver, expected-write scoreboard, write monitor.
module tb_config_word_loader;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, cfg_bit, cfg_valid;
  logic         cfg_ready, wr_en, busy, done, err;
  logic [W-1:0] wr_data;
  logic [N-1:0] wr_sel;

  int checks = 0;
  int errors = 0;

  logic [N+W-1:0] exp_q[$];

  config_word_loader #(.N_WORDS(N), .WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_bit   (cfg_bit),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .wr_data   (wr_data),
    .wr_sel    (wr_sel),
    .wr_en     (wr_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Every write must match the next scoreboard entry; wr_sel one-hot only with wr_en.
  always @(negedge clk) begin
    logic [N+W-1:0] e;
    check("sel_onehot", wr_en ? 32'($onehot(wr_sel)) : 32'(wr_sel == '0), 1);
    if (wr_en) begin
      check("ready_in_write", cfg_ready, 0);
      if (exp_q.size() == 0) begin
        check("unexpected_write", wr_en, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_sel", wr_sel, e[N+W-1:W]);
        check("wr_data", wr_data, e[W-1:0]);
      end
    end
  end

  // mode: 0 always valid, 1 toggling valid, 2 random valid. bad_word<0 means all parity good.
  task automatic run_load(input logic [N*W-1:0] words, input int bad_word, input int mode,
                          input int start_at);
    bit bits[$];
    logic [W-1:0] w;
    int idx;
    int budget;
    logic v;
    logic acc;
    logic exp_err;
    exp_err = 1'b0;
    for (int i = 0; i < N; i++) begin
      w = words[i*W +: W];
      for (int b = W - 1; b >= 0; b--) bits.push_back(w[b]);
`ifdef CFG_PARITY_EN
      bits.push_back((^w) ^ (i == bad_word));
      if (i == bad_word) exp_err = 1'b1;
      else exp_q.push_back({N'(1) << i, w});
`else
      exp_q.push_back({N'(1) << i, w});
`endif
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("ready_after_start", cfg_ready, 1);
    check("done_after_start", done, 0);
    check("busy_after_start", busy, 1);
    check("err_after_start", err, 0);
    idx = 0;
    budget = 4000;
    while (bits.size() > 0 && budget > 0) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = idx[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      cfg_valid = v;
      cfg_bit   = bits[0];
      start     = (idx == start_at);
      acc       = v && cfg_ready;
      @(negedge clk);
      if (acc) void'(bits.pop_front());
      idx++;
      budget--;
    end
    cfg_valid = 1'b0;
    start     = 1'b0;
    check("bits_consumed", bits.size(), 0);
    for (int k = 0; k < 6 && !done; k++) @(negedge clk);
    check("done_end", done, 1);
    check("busy_end", busy, 0);
    check("writes_all_seen", exp_q.size(), 0);
    check("err_end", err, exp_err);
    exp_q.delete();
  endtask

  initial begin
    logic [N*W-1:0] rw;
    int bad;
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] rw;
    int bad;
    rst_n = 1'b0;
    start = 1'b0;
    cfg_bit = 1'b0;
    cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", cfg_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_sel", wr_sel, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_load({8'h01, 8'hFF, 8'h3C, 8'hA5}, -1, 0, -1);
    run_load({8'h01, 8'hFF, 8'h3C, 8'hA5}, -1, 1, -1);
    run_load(32'($urandom), -1, 2, 7);
    run_load(32'($urandom), -1, 0, 8);
`ifdef CFG_PARITY_EN
    run_load({8'h01, 8'hFF, 8'h3C, 8'hA5}, 2, 0, -1);
    run_load(32'($urandom), -1, 1, -1);
`endif
    for (int r = 0; r < 4; r++) begin
      rw = 32'($urandom);
`ifdef CFG_PARITY_EN
      bad = int'($urandom_range(0, N)) - 1;
`else
      bad = -1;
`endif
      run_load(rw, bad, int'($urandom_range(0, 2)), int'($urandom_range(0, 40)));
    end

    // Abort mid-word: outputs drop at once and nothing gets written afterwards.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cfg_bit = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("busy_before_abort", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_ready", cfg_ready, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_sel", wr_sel, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_abort", cfg_ready, 0);
    check("busy_after_abort", busy, 0);
    cfg_valid = 1'b0;
    run_load({8'h01, 8'hFF, 8'h3C, 8'hA5}, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
